reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter owning a single shared register.
// A winner is granted in IDLE, commits its lane in GRANT, and the result is held for one COMMIT cycle.
module reg_write_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qbar,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [1:0]       win;
    logic [1:0]       win_n;
    logic [1:0]       cand;
    logic [3:0]       gnt_n;
    logic [3:0]       ack_n;
    logic [WIDTH-1:0] q_n;
    logic             busy_n;

    // Highest-priority requester: scan lowest priority first so the ptr slot is written last.
    always_comb begin
        cand = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                cand = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        gnt_n   = gnt;
        ack_n   = 4'b0000;
        q_n     = q;

        case (state)
            IDLE: begin
                if (|req) begin
                    win_n   = cand;
                    gnt_n   = 4'b0001 << cand;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[win]) begin
                    q_n     = wdata[32'(win) * WIDTH +: WIDTH];
                    ack_n   = 4'b0001 << win;
                    ptr_n   = win + 2'd1;
                    state_n = COMMIT;
                end else begin
                    // Winner withdrew before committing: drop the grant, keep q and ptr.
                    gnt_n   = 4'b0000;
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                gnt_n   = 4'b0000;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = 4'b0000;
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            win   <= 2'd0;
            gnt   <= 4'b0000;
            ack   <= 4'b0000;
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            win   <= win_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end

    assign qbar = ~q;

endmodule
